me_run_ctrl: RTL and testbench

Run controller between board push-buttons and the motion-estimation core's req/ack handshake. Supersedes the ad-hoc edge-detect/req flop at FPGA top level. Adds:
- debounced start/stop buttons
- single-shot or continuous run mode
- request timeout
- a HIST_DEPTH-entry history of (min_sad, min_mvec) results, readable by index for the 7-seg display mux
- a saturating run counter

---
 rtl/me_run_ctrl_pkg.sv | 27 ++
 rtl/me_btn_debounce.sv | 56 +++++
 rtl/me_run_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_me_run_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/me_run_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : me_pkg
// Brief  : Shared widths, FSM state encoding and history entry type for the
//          motion-estimation run controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package me_pkg;

  localparam int SAD_W_DEF  = 16;
  localparam int MVEC_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAD_W_DEF-1:0]  sad;
    logic [MVEC_W_DEF-1:0] mvec;
  } hist_entry_t;

endpackage

`default_nettype wire

// File: rtl/me_btn_debounce.sv
//------------------------------------------------------------------------------
// Module : me_btn_debounce
// Brief  : Two-flop synchroniser, stability counter and 1-cycle press pulse
//          for an active-low push-button.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module me_btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] c_last = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_s1      <= btn_n;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      // Any cycle of agreement restarts the stability count.
      if (r_s2 != r_level) begin
        if (r_cnt == c_last) begin
          r_level <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pulse = r_level_d & ~r_level;

endmodule

`default_nettype wire

// File: rtl/me_run_ctrl.sv
//------------------------------------------------------------------------------
// Module : me_run_ctrl
// Brief  : Push-button run controller for the ME core req/ack handshake with
//          timeout, result history and run counter. Optional best-result
//          tracking is enabled by defining ME_RUN_CTRL_BEST_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module me_run_ctrl
  import me_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int SAD_W      = SAD_W_DEF,
  parameter int MVEC_W     = MVEC_W_DEF,
  parameter int HIST_DEPTH = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_n,
  input  logic                          stop_n,
  input  logic                          mode_cont,
  output logic                          req,
  input  logic                          ack,
  input  logic [SAD_W-1:0]              min_sad,
  input  logic [MVEC_W-1:0]             min_mvec,
  input  logic [$clog2(HIST_DEPTH)-1:0] res_sel,
  output logic [SAD_W-1:0]              res_sad,
  output logic [MVEC_W-1:0]             res_mvec,
  output logic [15:0]                   run_cnt,
  output logic                          busy,
  output logic                          timeout,
  output logic [SAD_W-1:0]              best_sad,
  output logic [MVEC_W-1:0]             best_mvec
);

  localparam int IDXW = $clog2(HIST_DEPTH);
  // Timeout fires on the edge where the counter would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] c_tlast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic start_p;
  logic stop_p;

  me_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (start_n),
    .pulse (start_p)
  );

  me_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (stop_n),
    .pulse (stop_p)
  );

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_launch;
  logic                   w_capture;
  logic                   w_tmo_hit;
  logic                   w_clr_cont;
  logic                   w_reenter;
  logic                   r_cont;
  logic                   r_timeout;
  logic [TIMEOUT_W-1:0]   r_tcnt;
  logic [IDXW-1:0]        r_wp;
  logic [IDXW-1:0]        w_rd_idx;
  hist_entry_t            r_hist [HIST_DEPTH];
  logic [15:0]            r_run_cnt;
  logic [SAD_W-1:0]       r_res_sad;
  logic [MVEC_W-1:0]      r_res_mvec;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_capture  = 1'b0;
    w_tmo_hit  = 1'b0;
    w_clr_cont = 1'b0;
    w_reenter  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_p && !stop_p) begin
          w_next   = REQ;
          w_launch = 1'b1;
        end
      end
      REQ: begin
        if (ack) begin
          w_capture  = 1'b1;
          w_clr_cont = stop_p;
          w_next     = WAIT_LOW;
        end else if (stop_p) begin
          w_clr_cont = 1'b1;
          w_next     = WAIT_LOW;
        end else if (r_tcnt == c_tlast) begin
          w_tmo_hit = 1'b1;
          w_next    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        w_clr_cont = stop_p;
        if (!ack) begin
          if (r_cont && !stop_p) begin
            w_next    = REQ;
            w_reenter = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_rd_idx = r_wp - IDXW'(1) - res_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cont     <= 1'b0;
      r_timeout  <= 1'b0;
      r_tcnt     <= '0;
      r_wp       <= '0;
      r_run_cnt  <= '0;
      r_res_sad  <= '0;
      r_res_mvec <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else begin
      if (w_launch) begin
        r_cont    <= mode_cont;
        r_timeout <= 1'b0;
      end else if (w_clr_cont) begin
        r_cont <= 1'b0;
      end
      if (w_tmo_hit) r_timeout <= 1'b1;

      if (w_launch || w_reenter) r_tcnt <= '0;
      else if (r_state == REQ)   r_tcnt <= r_tcnt + 1'b1;

      if (w_capture) begin
        r_hist[r_wp].sad  <= SAD_W_DEF'(min_sad);
        r_hist[r_wp].mvec <= MVEC_W_DEF'(min_mvec);
        r_wp              <= r_wp + 1'b1;
        if (r_run_cnt != 16'hFFFF) r_run_cnt <= r_run_cnt + 16'd1;
      end

      r_res_sad  <= SAD_W'(r_hist[w_rd_idx].sad);
      r_res_mvec <= MVEC_W'(r_hist[w_rd_idx].mvec);
    end
  end

`ifdef ME_RUN_CTRL_BEST_EN
  logic [SAD_W-1:0]  r_best_sad;
  logic [MVEC_W-1:0] r_best_mvec;
  logic              r_best_vld;

  // Strict less-than so a tie keeps the earlier vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_best_sad  <= '0;
      r_best_mvec <= '0;
      r_best_vld  <= 1'b0;
    end else if (w_launch) begin
      r_best_vld <= 1'b0;
    end else if (w_capture && (!r_best_vld || (min_sad < r_best_sad))) begin
      r_best_sad  <= min_sad;
      r_best_mvec <= min_mvec;
      r_best_vld  <= 1'b1;
    end
  end

  assign best_sad  = r_best_sad;
  assign best_mvec = r_best_mvec;
`else
  assign best_sad  = '0;
  assign best_mvec = '0;
`endif

  assign req      = (r_state == REQ);
  assign busy     = (r_state != IDLE);
  assign timeout  = r_timeout;
  assign run_cnt  = r_run_cnt;
  assign res_sad  = r_res_sad;
  assign res_mvec = r_res_mvec;

endmodule

`default_nettype wire

// File: tb/tb_me_run_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_me_run_ctrl
// Brief  : Directed self-checking bench for me_run_ctrl.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_me_run_ctrl;

  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_n;
  logic        stop_n;
  logic        mode_cont;
  logic        req;
  logic        ack;
  logic [15:0] min_sad;
  logic [11:0] min_mvec;
  logic [1:0]  res_sel;
  logic [15:0] res_sad;
  logic [11:0] res_mvec;
  logic [15:0] run_cnt;
  logic        busy;
  logic        timeout;
  logic [15:0] best_sad;
  logic [11:0] best_mvec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  me_run_ctrl #(
    .DEB_CYCLES (DEB),
    .SAD_W      (16),
    .MVEC_W     (12),
    .HIST_DEPTH (4),
    .TIMEOUT_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_n   (start_n),
    .stop_n    (stop_n),
    .mode_cont (mode_cont),
    .req       (req),
    .ack       (ack),
    .min_sad   (min_sad),
    .min_mvec  (min_mvec),
    .res_sel   (res_sel),
    .res_sad   (res_sad),
    .res_mvec  (res_mvec),
    .run_cnt   (run_cnt),
    .busy      (busy),
    .timeout   (timeout),
    .best_sad  (best_sad),
    .best_mvec (best_mvec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Returns in the first REQ cycle.
  task automatic press_start();
    start_n = 1'b0;
    wait_cycles(DEB + 3);
    start_n = 1'b1;
    chk("start_req", {31'd0, req}, 32'd1);
  endtask

  // Returns with the stop pulse live for the next edge.
  task automatic arm_stop();
    stop_n = 1'b0;
    wait_cycles(DEB + 2);
  endtask

  task automatic read_chk(input logic [1:0] sel, input logic [15:0] es, input logic [11:0] em);
    res_sel = sel;
    tick();
    chk("res_sad", {16'd0, res_sad}, {16'd0, es});
    chk("res_mvec", {20'd0, res_mvec}, {20'd0, em});
  endtask

  // Capture in REQ, then return to REQ via WAIT_LOW in continuous mode.
  task automatic cap_cont(input logic [15:0] s, input logic [11:0] m);
    ack = 1'b1; min_sad = s; min_mvec = m;
    tick();
    chk("cap_req_low", {31'd0, req}, 32'd0);
    ack = 1'b0;
    tick();
    chk("cap_req_again", {31'd0, req}, 32'd1);
  endtask

  // Final capture, then stop while ack is still held in WAIT_LOW.
  task automatic cap_last_stop(input logic [15:0] s, input logic [11:0] m);
    ack = 1'b1; min_sad = s; min_mvec = m;
    tick();
    chk("last_req_low", {31'd0, req}, 32'd0);
    arm_stop();
    tick();
    stop_n = 1'b1;
    ack = 1'b0;
    tick();
    chk("stop_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic seen_req;
    rst_n = 1'b0; start_n = 1'b1; stop_n = 1'b1; mode_cont = 1'b0;
    ack = 1'b0; min_sad = '0; min_mvec = '0; res_sel = '0;
    wait_cycles(3);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_run_cnt", {16'd0, run_cnt}, 32'd0);
    chk("rst_res_sad", {16'd0, res_sad}, 32'd0);
    chk("rst_best_sad", {16'd0, best_sad}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Bounce, then a clean single-shot run
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start_n = ~start_n;
      for (int j = 0; j < 3; j++) begin
        tick();
        seen_req |= req;
      end
    end
    start_n = 1'b0;
    for (int j = 0; j < DEB + 2; j++) begin
      tick();
      seen_req |= req;
    end
    chk("bounce_no_early_req", {31'd0, seen_req}, 32'd0);
    tick();
    chk("bounce_req_rise_19", {31'd0, req}, 32'd1);
    wait_cycles(9);
    ack = 1'b1; min_sad = 16'h0123; min_mvec = 12'h045;
    tick();
    chk("ss_req_drop", {31'd0, req}, 32'd0);
    chk("ss_busy_wait", {31'd0, busy}, 32'd1);
    ack = 1'b0;
    tick();
    chk("ss_busy_idle", {31'd0, busy}, 32'd0);
    chk("ss_run_cnt", {16'd0, run_cnt}, 32'd1);
    read_chk(2'd0, 16'h0123, 12'h045);
    read_chk(2'd1, 16'h0000, 12'h000);
    seen_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      seen_req |= busy;
    end
    chk("ss_single_pulse", {31'd0, seen_req}, 32'd0);
    start_n = 1'b1;
    wait_cycles(DEB + 4);

    // Continuous run with history wrap
    mode_cont = 1'b1;
    press_start();
    for (int n = 1; n <= 5; n++) cap_cont(16'(n), 12'(12'h100 + n));
    cap_last_stop(16'd6, 12'h106);
    chk("wrap_run_cnt", {16'd0, run_cnt}, 32'd7);
    read_chk(2'd0, 16'd6, 12'h106);
    read_chk(2'd1, 16'd5, 12'h105);
    read_chk(2'd2, 16'd4, 12'h104);
    read_chk(2'd3, 16'd3, 12'h103);
    wait_cycles(DEB + 4);

    // Timeout with ack never rising
    mode_cont = 1'b0;
    press_start();
    wait_cycles(14);
    chk("tmo_req_held", {31'd0, req}, 32'd1);
    chk("tmo_not_yet", {31'd0, timeout}, 32'd0);
    tick();
    chk("tmo_req_drop", {31'd0, req}, 32'd0);
    chk("tmo_flag", {31'd0, timeout}, 32'd1);
    tick();
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    chk("tmo_no_capture", {16'd0, run_cnt}, 32'd7);
    wait_cycles(DEB + 4);

    // ack and stop_p in the same REQ cycle, continuous mode
    mode_cont = 1'b1;
    start_n = 1'b0;
    wait_cycles(10);
    stop_n = 1'b0;
    wait_cycles(DEB + 3 - 10);
    start_n = 1'b1;
    chk("race_req", {31'd0, req}, 32'd1);
    chk("race_tmo_cleared", {31'd0, timeout}, 32'd0);
    wait_cycles(9);
    ack = 1'b1; min_sad = 16'h0AAA; min_mvec = 12'h0BB;
    tick();
    stop_n = 1'b1;
    chk("race_req_drop", {31'd0, req}, 32'd0);
    chk("race_run_cnt", {16'd0, run_cnt}, 32'd8);
    ack = 1'b0;
    tick();
    chk("race_idle", {31'd0, busy}, 32'd0);
    read_chk(2'd0, 16'h0AAA, 12'h0BB);
    read_chk(2'd1, 16'd6, 12'h106);
    wait_cycles(DEB + 4);

    // Reset while in REQ
    mode_cont = 1'b0;
    press_start();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_req", {31'd0, req}, 32'd0);
    chk("rst_mid_run_cnt", {16'd0, run_cnt}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_res", {16'd0, res_sad}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(DEB + 4);

    // Best tracking: 50/A, 20/B, 20/C, 70/D
    mode_cont = 1'b1;
    press_start();
    cap_cont(16'd50, 12'h00A);
    cap_cont(16'd20, 12'h00B);
    cap_cont(16'd20, 12'h00C);
    cap_last_stop(16'd70, 12'h00D);
    chk("best_run_cnt", {16'd0, run_cnt}, 32'd4);
    read_chk(2'd0, 16'd70, 12'h00D);
`ifdef ME_RUN_CTRL_BEST_EN
    chk("best_sad", {16'd0, best_sad}, 32'd20);
    chk("best_mvec", {20'd0, best_mvec}, 32'h00B);
`else
    chk("best_sad", {16'd0, best_sad}, 32'd0);
    chk("best_mvec", {20'd0, best_mvec}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
